// File: rtl/ddr_cmd_sched.sv
// DDR1 command scheduler: one request at a time, ACTIVE then READ/WRITE with auto-precharge.
// Auto-refresh takes priority over user requests; the state is visible on dbg_state.
module ddr_cmd_sched #(
  parameter int BA_BITS  = 2,
  parameter int ROW_BITS = 13,
  parameter int COL_BITS = 10,
  parameter int T_RCD    = 3,
  parameter int T_RECOV  = 6,
  parameter int T_RFC    = 10,
  parameter int T_REFI   = 780
) (
  input  logic                                 core_clk,
  input  logic                                 core_rstn_sync,
  input  logic                                 init_done,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic                                 req_write,
  input  logic [BA_BITS+ROW_BITS+COL_BITS-1:0] req_addr,
  output logic                                 cmd_cs_n,
  output logic                                 cmd_ras_n,
  output logic                                 cmd_cas_n,
  output logic                                 cmd_we_n,
  output logic [BA_BITS-1:0]                   cmd_ba,
  output logic [ROW_BITS-1:0]                  cmd_a,
  output logic                                 rd_issue,
  output logic                                 wr_issue,
  output logic                                 ref_busy,
  output logic [2:0]                           dbg_state
);

  localparam int ADDR_W = BA_BITS + ROW_BITS + COL_BITS;
  localparam int REFI_W = $clog2(T_REFI);
  localparam int WAIT_W = $clog2(T_RCD + T_RECOV + T_RFC + 1);

  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_AREF  = 4'b0001;
  localparam logic [3:0] CMD_DESEL = 4'b1111;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_ACT, S_TRCD, S_RW, S_RECOV, S_REF, S_TRFC
  } state_t;

  state_t              state, state_n;
  logic [WAIT_W-1:0]   wait_cnt, wait_n;
  logic [REFI_W-1:0]   ref_cnt, ref_cnt_n;
  logic                ref_pend, ref_pend_n, ref_wrap;
  logic [ADDR_W-1:0]   addr_q, addr_n;
  logic                write_q, write_n;
  logic                take_req;
  logic [3:0]          cmd_n;
  logic [BA_BITS-1:0]  ba_n;
  logic [ROW_BITS-1:0] a_n, col_a;
  logic                ready_n, rd_n, wr_n, busy_n;

  assign dbg_state = state;

  // Handshake: a request is taken on any clock edge where req_valid && req_ready;
  // req_ready is registered and only ever high in S_IDLE with no refresh pending.
  assign take_req = req_valid && req_ready;
  assign ref_wrap = (ref_cnt == REFI_W'(T_REFI - 1));

  always_comb begin
    state_n    = state;
    wait_n     = wait_cnt;
    addr_n     = addr_q;
    write_n    = write_q;
    ref_cnt_n  = ref_wrap ? '0 : ref_cnt + REFI_W'(1);
    ref_pend_n = ref_pend || ref_wrap;
    if (!init_done) begin
      state_n    = S_INIT;
      ref_cnt_n  = '0;
      ref_pend_n = 1'b0;
    end else begin
      case (state)
        S_INIT: state_n = S_IDLE;
        S_IDLE: begin
          if (ref_pend) begin
            state_n    = S_REF;
            ref_pend_n = ref_wrap;
          end else if (take_req) begin
            state_n = S_ACT;
            addr_n  = req_addr;
            write_n = req_write;
          end
        end
        S_ACT: begin
          state_n = (T_RCD > 1) ? S_TRCD : S_RW;
          wait_n  = WAIT_W'((T_RCD > 1) ? T_RCD - 2 : 0);
        end
        S_TRCD: begin
          if (wait_cnt == '0) state_n = S_RW;
          else                wait_n  = wait_cnt - WAIT_W'(1);
        end
        S_RW: begin
          state_n = S_RECOV;
          wait_n  = WAIT_W'(T_RECOV - 1);
        end
        S_RECOV: begin
          if (wait_cnt == '0) state_n = S_IDLE;
          else                wait_n  = wait_cnt - WAIT_W'(1);
        end
        S_REF: begin
          state_n = (T_RFC > 1) ? S_TRFC : S_IDLE;
          wait_n  = WAIT_W'((T_RFC > 1) ? T_RFC - 2 : 0);
        end
        S_TRFC: begin
          if (wait_cnt == '0) state_n = S_IDLE;
          else                wait_n  = wait_cnt - WAIT_W'(1);
        end
        default: state_n = S_INIT;
      endcase
    end
  end

  // Bus values are decoded from the next state so every pin is a plain flop.
  always_comb begin
    col_a                 = '0;
    col_a[COL_BITS-1:0]   = addr_n[COL_BITS-1:0];
    col_a[10]             = 1'b1;
    cmd_n   = CMD_NOP;
    ba_n    = '0;
    a_n     = '0;
    rd_n    = 1'b0;
    wr_n    = 1'b0;
    busy_n  = (state_n == S_REF) || (state_n == S_TRFC);
    ready_n = (state_n == S_IDLE) && !ref_pend_n;
    case (state_n)
      S_INIT: cmd_n = CMD_DESEL;
      S_ACT: begin
        cmd_n = CMD_ACT;
        ba_n  = addr_n[ADDR_W-1 -: BA_BITS];
        a_n   = addr_n[COL_BITS +: ROW_BITS];
      end
      S_RW: begin
        cmd_n = write_n ? CMD_WRITE : CMD_READ;
        ba_n  = addr_n[ADDR_W-1 -: BA_BITS];
        a_n   = col_a;
        rd_n  = !write_n;
        wr_n  = write_n;
      end
      S_REF:   cmd_n = CMD_AREF;
      default: cmd_n = CMD_NOP;
    endcase
  end

  always_ff @(posedge core_clk or negedge core_rstn_sync) begin
    if (!core_rstn_sync) begin
      state     <= S_INIT;
      wait_cnt  <= '0;
      ref_cnt   <= '0;
      ref_pend  <= 1'b0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      {cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n} <= CMD_DESEL;
      cmd_ba    <= '0;
      cmd_a     <= '0;
      req_ready <= 1'b0;
      rd_issue  <= 1'b0;
      wr_issue  <= 1'b0;
      ref_busy  <= 1'b0;
    end else begin
      state     <= state_n;
      wait_cnt  <= wait_n;
      ref_cnt   <= ref_cnt_n;
      ref_pend  <= ref_pend_n;
      addr_q    <= addr_n;
      write_q   <= write_n;
      {cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n} <= cmd_n;
      cmd_ba    <= ba_n;
      cmd_a     <= a_n;
      req_ready <= ready_n;
      rd_issue  <= rd_n;
      wr_issue  <= wr_n;
      ref_busy  <= busy_n;
    end
  end

endmodule

// File: tb/tb_ddr_cmd_sched.sv
// Bench for ddr_cmd_sched: a timeline model predicts the cycle of every command and
// handshake; a negedge monitor compares bus activity against those predictions.
module tb_ddr_cmd_sched;

  localparam int BA    = 2;
  localparam int ROW   = 13;
  localparam int COL   = 10;
  localparam int RCD   = 3;
  localparam int RECOV = 6;
  localparam int RFC   = 10;
  localparam int REFI  = 780;
  localparam int AW    = BA + ROW + COL;
  localparam int EW    = 32 + 1 + 4 + BA + ROW + 2;

  logic            core_clk = 1'b0;
  logic            core_rstn_sync, init_done, req_valid, req_write;
  logic [AW-1:0]   req_addr;
  logic            req_ready, cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n;
  logic [BA-1:0]   cmd_ba;
  logic [ROW-1:0]  cmd_a;
  logic            rd_issue, wr_issue, ref_busy;
  logic [2:0]      dbg_state;

  ddr_cmd_sched #(
    .BA_BITS(BA), .ROW_BITS(ROW), .COL_BITS(COL), .T_RCD(RCD),
    .T_RECOV(RECOV), .T_RFC(RFC), .T_REFI(REFI)
  ) dut (
    .core_clk(core_clk), .core_rstn_sync(core_rstn_sync), .init_done(init_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .cmd_cs_n(cmd_cs_n), .cmd_ras_n(cmd_ras_n),
    .cmd_cas_n(cmd_cas_n), .cmd_we_n(cmd_we_n), .cmd_ba(cmd_ba), .cmd_a(cmd_a),
    .rd_issue(rd_issue), .wr_issue(wr_issue), .ref_busy(ref_busy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 core_clk = ~core_clk;

  int   cyc = 0;
  logic act = 1'b0;
  always @(posedge core_clk) begin
    cyc = cyc + 1;
    act = init_done;
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            hs_q[$];
  int            checks = 0;
  int            failures = 0;
  int            m_idle_at, m_next_ref, m_hs;
  bit            m_on = 1'b0;
  int            busy_s = -1;
  int            busy_e = -1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input int c, input logic care, input logic [3:0] cmd,
                                       input logic [BA-1:0] ba, input logic [ROW-1:0] a,
                                       input logic rd, input logic wr);
    return {32'(c), care, cmd, ba, a, rd, wr};
  endfunction

  // ---------------- reference model (timeline of the command bus) ----------------
  task automatic do_ref();
    int a;
    a = ((m_next_ref > m_idle_at) ? m_next_ref : m_idle_at) + 1;
    exp_q.push_back(mk(a, 1'b0, 4'b0001, '0, '0, 1'b0, 1'b0));
    m_idle_at  = a + RFC;
    m_next_ref = m_next_ref + REFI;
  endtask

  task automatic advance(input int c);
    while (m_next_ref <= c) do_ref();
  endtask

  task automatic model_req(input int v, input logic wr, input logic [AW-1:0] addr, output int h);
    logic [BA-1:0]  ba;
    logic [ROW-1:0] row, ca;
    ba  = addr[AW-1 -: BA];
    row = addr[COL +: ROW];
    ca  = ROW'(addr[COL-1:0]) + ROW'(1024);
    h = (v > m_idle_at) ? v : m_idle_at;
    while (m_next_ref <= h) begin
      do_ref();
      h = (v > m_idle_at) ? v : m_idle_at;
    end
    hs_q.push_back(h);
    exp_q.push_back(mk(h + 1, 1'b1, 4'b0011, ba, row, 1'b0, 1'b0));
    exp_q.push_back(mk(h + 1 + RCD, 1'b1, wr ? 4'b0100 : 4'b0101, ba, ca, !wr, wr));
    m_idle_at = h + RCD + RECOV + 2;
    m_hs      = h;
  endtask

  task automatic purge(input int d);
    logic [EW-1:0] keep[$];
    logic [EW-1:0] e;
    int            hk[$];
    foreach (exp_q[i]) begin
      e = exp_q[i];
      if (int'(e[EW-1 -: 32]) <= d) keep.push_back(e);
    end
    foreach (hs_q[i]) if (hs_q[i] <= d) hk.push_back(hs_q[i]);
    exp_q = keep;
    hs_q  = hk;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge core_clk);
    #1;
    if (m_on) advance(cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = AW'($urandom);
    end
  endtask

  task automatic do_req(input logic wr, input logic [AW-1:0] addr);
    int h;
    tick();
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    model_req(cyc, wr, addr, h);
    while (cyc < h) tick();
  endtask

  task automatic set_init(input logic v);
    tick();
    req_valid = 1'b0;
    init_done = v;
    if (v) begin
      m_on       = 1'b1;
      m_idle_at  = cyc + 1;
      m_next_ref = cyc + REFI;
      m_hs       = -10;
    end else begin
      m_on = 1'b0;
      purge(cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge core_clk) begin
    logic [3:0]    cmd;
    logic [EW-1:0] f;
    int            fc, h;
    logic          exp_ready, exp_busy;
    cmd = {cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n};
    if (!act) begin
      check("desel_idle", {cmd, cmd_ba, cmd_a, req_ready, rd_issue, wr_issue, ref_busy},
            {4'hF, {BA{1'b0}}, {ROW{1'b0}}, 4'b0000});
    end else begin
      if ((cmd != 4'b0111) || rd_issue || wr_issue ||
          (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) <= cyc)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_cmd", {cmd, rd_issue, wr_issue}, {4'b0111, 2'b00});
        end else begin
          f  = exp_q.pop_front();
          fc = int'(f[EW-1 -: 32]);
          check("cmd_cycle", 64'(cyc), 64'(fc));
          if (f[EW-33])
            check("cmd_fields", {cmd, cmd_ba, cmd_a, rd_issue, wr_issue}, f[EW-34:0]);
          else
            check("cmd_fields", {cmd, rd_issue, wr_issue}, {f[EW-34 -: 4], f[1:0]});
          if (f[EW-34 -: 4] == 4'b0001) begin
            busy_s = fc;
            busy_e = fc + RFC - 1;
          end
        end
      end
      exp_busy = (cyc >= busy_s) && (cyc <= busy_e);
      check("ref_busy", 64'(ref_busy), 64'(exp_busy));
      exp_ready = m_on && (((cyc >= m_idle_at) && (cyc < m_next_ref)) || (cyc == m_hs));
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      if (req_valid && req_ready) begin
        if (hs_q.size() == 0) begin
          check("unexpected_handshake", 64'(cyc), 64'(-1));
        end else begin
          h = hs_q.pop_front();
          check("handshake_cycle", 64'(cyc), 64'(h));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    core_rstn_sync = 1'b0;
    init_done      = 1'b0;
    req_valid      = 1'b0;
    req_write      = 1'b0;
    req_addr       = '0;
    repeat (2) @(posedge core_clk);
    #1 core_rstn_sync = 1'b1;

    // init_done rises during cycle 5
    while (cyc < 4) tick();
    set_init(1'b1);
    idle(10);

    // directed read: bank 2, row 0x123, col 0x45
    do_req(1'b0, {2'd2, 13'h123, 10'h045});
    idle(15);

    // back-to-back writes with valid held high
    repeat (3) do_req(1'b1, AW'($urandom));
    idle(5);

    // long idle: two refreshes one interval apart
    idle(1700);

    // refresh falls due during tRCD with a second request already waiting
    idle(20);
    while (m_next_ref - cyc != 3) idle(1);
    do_req(1'b0, AW'($urandom));
    do_req(1'b1, AW'($urandom));
    idle(30);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 15);
      if (gap > 0) idle(gap);
      do_req(1'($urandom_range(0, 1)), AW'($urandom));
    end
    idle(20);

    // init_done dropped during recovery, then restored
    do_req(1'b0, AW'($urandom));
    idle(RCD + 2);
    set_init(1'b0);
    idle(6);
    set_init(1'b1);
    idle(REFI + 20);
    do_req(1'b1, AW'($urandom));
    idle(30);

    check("exp_q_drained", 64'(exp_q.size()), 64'(0));
    check("hs_q_drained", 64'(hs_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
